// File: rtl/hero_write_arb_if.sv
// Bundle of the hero write requester bus and the arbitrated output beat.
// The arbiter sits on the slave side; the requester/consumer side uses master.
interface hero_write_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int HERO_WIDTH = 36
);
    localparam int OWNER_W = $clog2(NUM_REQ);

    logic [2*NUM_REQ-1:0]          req_cycle_type;
    logic [HERO_WIDTH*NUM_REQ-1:0] req_wdat;
    logic [NUM_REQ-1:0]            req_ready;
    logic [1:0]                    out_cycle_type;
    logic [HERO_WIDTH-1:0]         out_wdat;
    logic [OWNER_W-1:0]            out_owner;
    logic                          out_ready;
    logic                          err_overrun;

    modport master (
        output req_cycle_type, req_wdat, out_ready,
        input  req_ready, out_cycle_type, out_wdat, out_owner, err_overrun
    );

    modport slave (
        input  req_cycle_type, req_wdat, out_ready,
        output req_ready, out_cycle_type, out_wdat, out_owner, err_overrun
    );
endinterface

// File: rtl/hero_write_arb.sv
// Round-robin write arbiter: locks onto a requester for a VALID..DONE transaction,
// registers one beat of output, and truncates transactions at MAX_BEATS.
module hero_write_arb #(
    parameter int NUM_REQ    = 4,
    parameter int HERO_WIDTH = 36,
    parameter int MAX_BEATS  = 64
) (
    input  logic             clk,
    input  logic             rst,
    hero_write_arb_if.slave  bus
);
    localparam int OWNER_W = $clog2(NUM_REQ);
    localparam int CNT_W   = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        CT_IDLE  = 2'd0,
        CT_VALID = 2'd1,
        CT_DONE  = 2'd2
    } cycle_type_e;

    typedef enum logic {
        ARB,
        LOCKED
    } state_e;

    state_e                state_q;
    logic [OWNER_W-1:0]    ptr_q;
    logic [OWNER_W-1:0]    owner_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [1:0]            out_type_q;
    logic [HERO_WIDTH-1:0] out_wdat_q;
    logic [OWNER_W-1:0]    out_owner_q;
    logic                  err_q;

    logic [1:0]            req_type [NUM_REQ];
    logic [HERO_WIDTH-1:0] req_data [NUM_REQ];
    logic [NUM_REQ-1:0]    requesting;
    logic [OWNER_W-1:0]    grant;
    logic [OWNER_W-1:0]    cand;
    logic                  grant_vld;
    logic                  load_en;
    logic                  accept;
    logic                  truncate;
    logic                  release_lock;
    logic [1:0]            acc_type;
    logic [OWNER_W-1:0]    ptr_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_type[i]   = bus.req_cycle_type[2*i +: 2];
            req_data[i]   = bus.req_wdat[HERO_WIDTH*i +: HERO_WIDTH];
            requesting[i] = (bus.req_cycle_type[2*i +: 2] != CT_IDLE);
        end
    end

    // Walk downward from ptr+NUM_REQ-1 so the nearest requester at/after ptr wins last.
    always_comb begin
        grant     = owner_q;
        grant_vld = 1'b0;
        cand      = '0;
        if (state_q == LOCKED) begin
            grant_vld = requesting[owner_q];
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                cand = OWNER_W'((int'(ptr_q) + k) % NUM_REQ);
                if (requesting[cand]) begin
                    grant     = cand;
                    grant_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        load_en      = (out_type_q == CT_IDLE) || bus.out_ready;
        accept       = load_en && grant_vld && !rst;
        acc_type     = req_type[grant];
        truncate     = accept && (acc_type == CT_VALID) && (cnt_q == CNT_W'(MAX_BEATS - 1));
        release_lock = accept && ((acc_type == CT_DONE) || truncate);
        ptr_d        = (grant == OWNER_W'(NUM_REQ - 1)) ? '0 : grant + OWNER_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB;
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            out_type_q <= CT_IDLE;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (load_en) begin
                out_type_q <= CT_IDLE;
                if (accept) begin
                    out_type_q <= truncate ? CT_DONE : acc_type;
                    err_q      <= truncate;
                    if (release_lock) begin
                        state_q <= ARB;
                        ptr_q   <= ptr_d;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= LOCKED;
                        owner_q <= grant;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    // NOTE: the data/owner payload is qualified by out_cycle_type, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            out_wdat_q  <= req_data[grant];
            out_owner_q <= grant;
        end
    end

    always_comb begin
        bus.req_ready      = accept ? (NUM_REQ'(1) << grant) : '0;
        bus.out_cycle_type = out_type_q;
        bus.out_wdat       = out_wdat_q;
        bus.out_owner      = out_owner_q;
        bus.err_overrun    = err_q;
    end
endmodule

// File: tb/tb_hero_write_arb.sv
// Randomised and directed bench for hero_write_arb; a transaction-level model
// predicts grants and output beats, and literal tables pin the directed cases.
module tb_hero_write_arb;
    localparam int N  = 4;
    localparam int W  = 36;
    localparam int MB = 4;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] VALID = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    typedef struct packed {
        logic [1:0]   t;
        logic [W-1:0] d;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hero_write_arb_if #(.NUM_REQ(N), .HERO_WIDTH(W)) bus ();

    hero_write_arb #(.NUM_REQ(N), .HERO_WIDTH(W), .MAX_BEATS(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    beat_t q [N][$];

    bit           m_locked = 1'b0;
    int           m_owner  = 0;
    int           m_ptr    = 0;
    int           m_cnt    = 0;
    logic [1:0]   m_type   = IDLE;
    logic [W-1:0] m_wdat   = '0;
    int           m_own    = 0;
    bit           m_err    = 1'b0;

    bit rst_drv  = 1'b1;
    bit ordy_drv = 1'b1;
    bit rst_pat  [16];
    bit ordy_pat [16];

    logic [1:0]   last_type;
    logic [N-1:0] last_ready;
    logic [1:0]   last_owner;
    logic [W-1:0] last_wdat;
    logic         last_err;
    logic [1:0]   lt [16];
    logic [N-1:0] lr [16];
    logic [1:0]   lo [16];
    logic [W-1:0] lw [16];
    logic         le [16];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int i, input logic [1:0] t);
        beat_t b;
        b.t = t;
        b.d = W'({$urandom(), $urandom()});
        q[i].push_back(b);
    endtask

    // One clock: drive queue heads after the edge, compare at the falling edge, then advance the model.
    task automatic run_cycle();
        logic [2*N-1:0] ct;
        logic [W*N-1:0] wd;
        logic [N-1:0]   exp_rdy;
        logic [1:0]     t;
        int             g;
        bit             load;
        bit             trunc;
        @(posedge clk);
        #1;
        // NOTE: the bench drives inputs with blocking assignments, well clear of the active edge.
        rst           = rst_drv;
        bus.out_ready = ordy_drv;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() != 0) begin
                ct[2*i +: 2] = q[i][0].t;
                wd[W*i +: W] = q[i][0].d;
            end else begin
                ct[2*i +: 2] = IDLE;
                wd[W*i +: W] = W'({$urandom(), $urandom()});
            end
        end
        bus.req_cycle_type = ct;
        bus.req_wdat       = wd;
        @(negedge clk);

        g    = -1;
        load = (m_type == IDLE) || ordy_drv;
        if (m_locked) begin
            if (ct[2*m_owner +: 2] != IDLE) g = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && ct[2*((m_ptr + k) % N) +: 2] != IDLE) g = (m_ptr + k) % N;
            end
        end
        exp_rdy = (load && !rst_drv && g >= 0) ? (N'(1) << g) : '0;

        check("req_ready", bus.req_ready, exp_rdy);
        check("out_cycle_type", bus.out_cycle_type, m_type);
        check("err_overrun", bus.err_overrun, m_err);
        if (m_type != IDLE) begin
            check("out_wdat", bus.out_wdat, m_wdat);
            check("out_owner", bus.out_owner, m_own);
        end
        last_type  = bus.out_cycle_type;
        last_ready = bus.req_ready;
        last_owner = bus.out_owner;
        last_wdat  = bus.out_wdat;
        last_err   = bus.err_overrun;

        if (rst_drv) begin
            m_locked = 1'b0;
            m_ptr    = 0;
            m_cnt    = 0;
            m_type   = IDLE;
            m_err    = 1'b0;
        end else begin
            m_err = 1'b0;
            if (load) begin
                if (g < 0) begin
                    m_type = IDLE;
                end else begin
                    t      = ct[2*g +: 2];
                    trunc  = (t == VALID) && (m_cnt + 1 == MB);
                    m_type = trunc ? DONE : t;
                    m_wdat = wd[W*g +: W];
                    m_own  = g;
                    m_err  = trunc;
                    if (t == DONE || trunc) begin
                        m_locked = 1'b0;
                        m_ptr    = (g + 1) % N;
                        m_cnt    = 0;
                    end else begin
                        m_locked = 1'b1;
                        m_owner  = g;
                        m_cnt    = m_cnt + 1;
                    end
                end
            end
        end

        for (int i = 0; i < N; i++) begin
            if (q[i].size() != 0 && (q[i][0].t == IDLE || exp_rdy[i])) void'(q[i].pop_front());
        end
    endtask

    task automatic run_log(input int n);
        for (int c = 0; c < n; c++) begin
            rst_drv  = rst_pat[c];
            ordy_drv = ordy_pat[c];
            run_cycle();
            lt[c] = last_type;
            lr[c] = last_ready;
            lo[c] = last_owner;
            lw[c] = last_wdat;
            le[c] = last_err;
        end
        rst_drv  = 1'b0;
        ordy_drv = 1'b1;
        for (int c = 0; c < 16; c++) begin
            rst_pat[c]  = 1'b0;
            ordy_pat[c] = 1'b1;
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        rst_drv  = 1'b1;
        ordy_drv = 1'b1;
        run_cycle();
        check("rst_ready", last_ready, 0);
        run_cycle();
        check("rst_out_idle", last_type, IDLE);
        rst_drv = 1'b0;
    endtask

    int           len;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    int           exp_own [5] = '{0, 1, 2, 3, 0};
    int           exp_rdy [5] = '{2, 2, 2, 4, 4};
    logic [1:0]   exp_e   [6] = '{VALID, VALID, VALID, DONE, VALID, VALID};

    initial begin
        bus.req_cycle_type = '0;
        bus.req_wdat       = '0;
        bus.out_ready      = 1'b1;
        for (int c = 0; c < 16; c++) begin
            rst_pat[c]  = 1'b0;
            ordy_pat[c] = 1'b1;
        end

        // Four continuous single-beat requesters rotate one grant per cycle.
        do_reset();
        for (int i = 0; i < N; i++) for (int b = 0; b < 8; b++) push(i, DONE);
        run_log(6);
        check("first_out_idle", lt[0], IDLE);
        for (int c = 0; c < 5; c++) begin
            check("rr_owner", lo[c+1], exp_own[c]);
            check("rr_type", lt[c+1], DONE);
        end

        // A locked transaction blocks a competing requester until its DONE.
        do_reset();
        push(1, VALID); push(1, VALID); push(1, DONE);
        push(2, DONE);  push(2, DONE);
        run_log(6);
        for (int c = 0; c < 5; c++) check("lock_ready", lr[c], exp_rdy[c]);

        // Backpressure holds a full output and stalls all requesters.
        do_reset();
        for (int b = 0; b < 6; b++) push(0, DONE);
        d0 = q[0][0].d;
        d1 = q[0][1].d;
        ordy_pat[1] = 1'b0; ordy_pat[2] = 1'b0; ordy_pat[3] = 1'b0;
        run_log(6);
        for (int c = 1; c < 4; c++) check("stall_ready", lr[c], 0);
        for (int c = 1; c < 5; c++) check("stall_hold", lw[c], d0);
        check("drain_ready", lr[4], 1);
        check("drain_next", lw[5], d1);

        // Owner idle cycles become bubbles without losing the lock.
        do_reset();
        push(0, VALID); push(0, IDLE); push(0, IDLE); push(0, DONE);
        push(1, DONE);  push(1, DONE); push(1, DONE); push(1, DONE);
        run_log(6);
        check("bubble_t1", lt[1], VALID);
        check("bubble_t2", lt[2], IDLE);
        check("bubble_t3", lt[3], IDLE);
        check("bubble_t4", lt[4], DONE);
        check("bubble_own", lo[4], 0);
        check("bubble_rdy1", lr[1], 0);
        check("bubble_rdy2", lr[2], 0);
        check("after_own", lo[5], 1);

        // Overlong transaction is cut at MB beats and restarts.
        do_reset();
        for (int b = 0; b < 6; b++) push(3, VALID);
        run_log(7);
        for (int c = 0; c < 6; c++) begin
            check("trunc_type", lt[c+1], exp_e[c]);
            check("trunc_err", le[c+1], (c == 3) ? 1'b1 : 1'b0);
        end

        // Reset in the middle of a transaction drops lock and output.
        do_reset();
        push(2, VALID); push(2, VALID); push(2, VALID); push(2, VALID); push(2, DONE);
        push(1, IDLE);  push(1, IDLE);  push(1, IDLE);  push(1, DONE);
        rst_pat[1] = 1'b1; rst_pat[2] = 1'b1;
        run_log(5);
        check("mid_rst_ready", lr[1], 0);
        check("mid_rst_idle", lt[2], IDLE);
        check("mid_rst_ready2", lr[2], 0);
        check("ptr_after_rst", lr[3], 4'b0010);

        // Random traffic, backpressure and occasional resets against the model.
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    len = $urandom_range(1, 7);
                    for (int b = 0; b < len; b++) begin
                        if (b > 0 && $urandom_range(0, 4) == 0) push(i, IDLE);
                        push(i, (b == len - 1) ? DONE : VALID);
                    end
                end
            end
            ordy_drv = ($urandom_range(0, 3) != 0);
            rst_drv  = ($urandom_range(0, 299) == 0);
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
